// File: rtl/sb_drain_controller.sv
// Store-buffer drain sequencer: arbitrates the single D-cache port between the MEM stage and
// SB head drains, and walks drain misses through a memory refill.
module sb_drain_controller #(
    parameter int SB_NLINES    = 4,
    parameter int CNT_W        = 3,
    parameter int DRAIN_THRESH = 3,
    parameter int MAX_WAIT     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] sb_count,
    input  logic             mem_is_load,
    input  logic             mem_is_store,
    input  logic             head_cache_hit,
    input  logic             mem_ack,
    input  logic             flush_req,
    output logic             sb_pop,
    output logic             cache_wr_en,
    output logic             mem_req,
    output logic             pipe_stall,
    output logic             flush_done,
    output logic [1:0]       drain_state
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WRITE  = 2'd1;
    localparam logic [1:0] ST_REFILL = 2'd2;

    localparam int                WAIT_W    = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0]  THRESH    = CNT_W'(DRAIN_THRESH);
    localparam logic [CNT_W-1:0]  FULL      = CNT_W'(SB_NLINES);

    logic [1:0]        state_r;
    logic [1:0]        state_next_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_next_s;
    logic              flush_pending_r;
    logic              flush_pending_next_s;
    logic              flush_done_r;
    logic              flush_complete_s;
    logic              port_busy_s;
    logic              sb_nonempty_s;
    logic              forced_s;
    logic              opportunistic_s;
    logic              drain_go_s;
    logic              pipe_stall_s;

    // Drain decision: forced drains take the port even from an active MEM op.
    always_comb begin
        port_busy_s      = mem_is_load | mem_is_store;
        sb_nonempty_s    = (sb_count != {CNT_W{1'b0}});
        forced_s         = (sb_count >= THRESH) | (wait_cnt_r == WAIT_LAST) | flush_pending_r;
        opportunistic_s  = sb_nonempty_s & ~port_busy_s;
        drain_go_s       = (state_r == ST_IDLE) & sb_nonempty_s & (forced_s | opportunistic_s);
        flush_complete_s = flush_pending_r & (state_r == ST_IDLE) & ~sb_nonempty_s;
    end

    // Next-state logic; the unused encoding falls back to IDLE.
    always_comb begin
        state_next_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (drain_go_s) begin
                    state_next_s = head_cache_hit ? ST_WRITE : ST_REFILL;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WRITE:  state_next_s = ST_IDLE;
            ST_REFILL: state_next_s = mem_ack ? ST_WRITE : ST_REFILL;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // Starvation counter and flush bookkeeping; a repeated flush_req while pending is absorbed.
    always_comb begin
        wait_cnt_next_s = wait_cnt_r;
        if (!sb_nonempty_s || drain_go_s) begin
            wait_cnt_next_s = {WAIT_W{1'b0}};
        end else if (state_r == ST_IDLE && wait_cnt_r != WAIT_LAST) begin
            wait_cnt_next_s = wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
        end else begin
            wait_cnt_next_s = wait_cnt_r;
        end
        flush_pending_next_s = flush_pending_r ? ~flush_complete_s : flush_req;
    end

    // Stall: the MEM stage loses the port to forced drains, a full SB, or an in-flight drain.
    always_comb begin
        pipe_stall_s = 1'b0;
        case (state_r)
            ST_IDLE:   pipe_stall_s = (drain_go_s & forced_s & port_busy_s)
                                    | (mem_is_store & (sb_count == FULL));
            ST_WRITE:  pipe_stall_s = port_busy_s;
            ST_REFILL: pipe_stall_s = port_busy_s;
            default:   pipe_stall_s = 1'b0;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r         <= ST_IDLE;
            wait_cnt_r      <= {WAIT_W{1'b0}};
            flush_pending_r <= 1'b0;
            flush_done_r    <= 1'b0;
        end else begin
            state_r         <= state_next_s;
            wait_cnt_r      <= wait_cnt_next_s;
            flush_pending_r <= flush_pending_next_s;
            flush_done_r    <= flush_complete_s;
        end
    end

    // Outputs are forced low for the whole reset-low cycle, so a refill request drops at once.
    assign sb_pop      = reset & (state_r == ST_WRITE);
    assign cache_wr_en = reset & (state_r == ST_WRITE);
    assign mem_req     = reset & (state_r == ST_REFILL);
    assign pipe_stall  = reset & pipe_stall_s;
    assign flush_done  = reset & flush_done_r;
    assign drain_state = reset ? state_r : 2'd0;

endmodule

// File: tb/tb_sb_drain_controller.sv
// Directed-vector bench for sb_drain_controller: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them.
module tb_sb_drain_controller;

    logic       clk;
    logic       reset;
    logic [2:0] sb_count;
    logic       mem_is_load;
    logic       mem_is_store;
    logic       head_cache_hit;
    logic       mem_ack;
    logic       flush_req;
    logic       sb_pop;
    logic       cache_wr_en;
    logic       mem_req;
    logic       pipe_stall;
    logic       flush_done;
    logic [1:0] drain_state;

    sb_drain_controller #(
        .SB_NLINES(4), .CNT_W(3), .DRAIN_THRESH(3), .MAX_WAIT(8)
    ) dut (
        .clk(clk), .reset(reset), .sb_count(sb_count),
        .mem_is_load(mem_is_load), .mem_is_store(mem_is_store),
        .head_cache_hit(head_cache_hit), .mem_ack(mem_ack), .flush_req(flush_req),
        .sb_pop(sb_pop), .cache_wr_en(cache_wr_en), .mem_req(mem_req),
        .pipe_stall(pipe_stall), .flush_done(flush_done), .drain_state(drain_state)
    );

    // Expected outputs {sb_pop, cache_wr_en, mem_req, pipe_stall, flush_done, drain_state}
    localparam logic [6:0] Z   = 7'b0000000;
    localparam logic [6:0] STL = 7'b0001000;
    localparam logic [6:0] WR  = 7'b1100001;
    localparam logic [6:0] WRS = 7'b1101001;
    localparam logic [6:0] RF  = 7'b0010010;
    localparam logic [6:0] RFS = 7'b0011010;
    localparam logic [6:0] FD  = 7'b0000100;

    // Inputs {reset, mem_is_load, mem_is_store, head_cache_hit, mem_ack, flush_req}
    localparam logic [5:0] I_NOP  = 6'b100000;
    localparam logic [5:0] I_HIT  = 6'b100100;
    localparam logic [5:0] I_LDH  = 6'b110100;
    localparam logic [5:0] I_STH  = 6'b101100;
    localparam logic [5:0] I_LD   = 6'b110000;
    localparam logic [5:0] I_ACK  = 6'b100010;
    localparam logic [5:0] I_LDF  = 6'b110101;
    localparam logic [5:0] I_FLR  = 6'b100001;
    localparam logic [5:0] I_RST  = 6'b000000;
    localparam logic [5:0] I_RSTS = 6'b001000;

    typedef struct {
        string      name;
        logic [6:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input logic [5:0] in_v, input logic [2:0] cnt, input logic [6:0] ev,
                       input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        {reset, mem_is_load, mem_is_store, head_cache_hit, mem_ack, flush_req} = in_v;
        sb_count = cnt;
        e.name = nm;
        e.val  = ev;
        exp_q.push_back(e);
    endtask

    // Monitor: compares the output vector against the oldest queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            logic [6:0] got;
            e   = exp_q.pop_front();
            got = {sb_pop, cache_wr_en, mem_req, pipe_stall, flush_done, drain_state};
            n_cmp++;
            if (got !== e.val) begin
                n_err++;
                $display("FAIL %s: got %b expected %b", e.name, got, e.val);
            end
        end
    end

    initial begin
        {reset, mem_is_load, mem_is_store, head_cache_hit, mem_ack, flush_req} = I_RST;
        sb_count = 3'd0;

        cyc(I_RST,  3'd0, Z, "reset0");
        cyc(I_RSTS, 3'd4, Z, "reset_full_store_no_stall");
        cyc(I_NOP,  3'd0, Z, "idle_after_reset");

        cyc(I_HIT, 3'd1, Z,  "t1_drain_go");
        cyc(I_HIT, 3'd1, WR, "t1_write");
        cyc(I_NOP, 3'd0, Z,  "t1_back_idle");

        cyc(I_LDH, 3'd3, STL, "t2_forced_stall");
        cyc(I_LDH, 3'd3, WRS, "t2_write_stall");
        cyc(I_NOP, 3'd0, Z,   "t2_idle");

        for (int k = 0; k < 7; k++) cyc(I_LDH, 3'd2, Z, "t3_waiting");
        cyc(I_LDH, 3'd2, STL, "t3_starve_forced");
        cyc(I_LDH, 3'd2, WRS, "t3_write");
        cyc(I_LDH, 3'd1, Z,   "t3_wait_restart");
        cyc(I_NOP, 3'd0, Z,   "t3_idle");

        cyc(I_NOP, 3'd1, Z,   "t4_miss_go");
        cyc(I_NOP, 3'd1, RF,  "t4_refill1");
        cyc(I_LD,  3'd1, RFS, "t4_refill2_load");
        cyc(I_NOP, 3'd1, RF,  "t4_refill3");
        cyc(I_ACK, 3'd1, RF,  "t4_refill4_ack");
        cyc(I_NOP, 3'd1, WR,  "t4_write");
        cyc(I_NOP, 3'd0, Z,   "t4_idle");

        cyc(I_STH, 3'd4, STL, "full_store_forced");
        cyc(I_STH, 3'd4, WRS, "full_store_write");
        cyc(I_NOP, 3'd0, Z,   "full_idle");

        cyc(I_LDF, 3'd2, Z,   "t5_flush_req");
        cyc(I_LDH, 3'd2, STL, "t5_flush_drain1");
        cyc(I_LDH, 3'd2, WRS, "t5_write1");
        cyc(I_LDH, 3'd1, STL, "t5_flush_drain2");
        cyc(I_LDH, 3'd1, WRS, "t5_write2");
        cyc(I_LD,  3'd0, Z,   "t5_empty");
        cyc(I_LD,  3'd0, FD,  "t5_flush_done");
        cyc(I_NOP, 3'd0, Z,   "t5_done_one_pulse");
        cyc(I_FLR, 3'd0, Z,   "t5b_flush_req");
        cyc(I_FLR, 3'd0, Z,   "t5b_pending_repeat");
        cyc(I_NOP, 3'd0, FD,  "t5b_flush_done");
        cyc(I_NOP, 3'd0, Z,   "t5b_no_extra");
        cyc(I_NOP, 3'd0, Z,   "t5b_quiet");

        cyc(I_NOP, 3'd1, Z,   "t6_miss_go");
        cyc(I_NOP, 3'd1, RF,  "t6_refill");
        cyc(I_RST, 3'd1, Z,   "t6_reset_drops_req");
        cyc(I_ACK, 3'd0, Z,   "t6_idle_late_ack");
        cyc(I_NOP, 3'd0, Z,   "t6_no_spurious_pop");
        cyc(I_NOP, 3'd0, Z,   "t6_quiet");

        repeat (2) @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_queue: got %0d left required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sb_drain_controller.md
Name: sb_drain_controller

Overview:
- Sequences draining of the store buffer into the data cache, and arbitrates the single cache port between the MEM stage (loads/stores) and SB drains.
- Drains opportunistically when the port is idle, forcibly on high occupancy, starvation timeout or flush.
- Handles drain misses through a memory refill handshake.
- Sits between the store buffer, the D-cache tag/write port and the memory interface; drives the pipeline stall.

Parameters:
SB_NLINES, 4, store buffer entries
CNT_W, 3, width of sb_count (holds 0..SB_NLINES)
DRAIN_THRESH, 3, occupancy at or above which a drain is forced
MAX_WAIT, 8, cycles a non-empty SB may go undrained before a forced drain

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
sb_count  in  CNT_W  current SB occupancy
mem_is_load  in  1  MEM stage load wants the cache port this cycle
mem_is_store  in  1  MEM stage store wants the cache port this cycle
head_cache_hit  in  1  tag lookup result for SB head entry address
mem_ack  in  1  memory refill of head line complete (1-cycle pulse)
flush_req  in  1  request to empty the SB (1-cycle pulse)
sb_pop  out  1  retire SB head entry
cache_wr_en  out  1  write SB head data into D-cache
mem_req  out  1  request refill of head line
pipe_stall  out  1  freeze MEM stage this cycle
flush_done  out  1  1-cycle pulse: flush complete
drain_state  out  2  current FSM state (debug)

Behaviour:
- States: IDLE=2'd0, WRITE=2'd1, REFILL=2'd2; 2'd3 unreachable, recovers to IDLE.
- reset low at a rising edge:
  - state->IDLE; wait_cnt, flush_pending and flush_done cleared.
  - While reset is low, all outputs are 0, including pipe_stall.
- port_busy = mem_is_load | mem_is_store.
- Forced drain: sb_count >= DRAIN_THRESH, or wait_cnt == MAX_WAIT-1, or flush_pending.
- Opportunistic drain: sb_count != 0 and !port_busy.
- drain_go in IDLE = sb_count != 0 and (forced or opportunistic).
- IDLE transitions:
  - drain_go & head_cache_hit -> WRITE.
  - drain_go & !head_cache_hit -> REFILL.
  - Otherwise stay in IDLE.
- WRITE lasts exactly 1 cycle: sb_pop=1, cache_wr_en=1, then IDLE.
- REFILL: mem_req=1 every cycle until the cycle mem_ack=1; next state WRITE. mem_ack outside REFILL is ignored.
- sb_pop, cache_wr_en and mem_req are Moore (decoded from state only). Minimum drain latency is 1 cycle from the drain_go cycle to sb_pop.
- pipe_stall (Mealy):
  - 1 in IDLE when drain_go & forced & port_busy (drain wins the port).
  - 1 in IDLE when mem_is_store & sb_count == SB_NLINES (SB full).
  - 1 in WRITE/REFILL when port_busy.
  - Otherwise 0.
- wait_cnt:
  - 0 when sb_count == 0 or drain_go.
  - Otherwise increments in IDLE, saturating at MAX_WAIT-1.
  - Holds in WRITE/REFILL.
- Flush:
  - flush_req sets flush_pending at the next edge.
  - While pending, every IDLE cycle with sb_count != 0 starts a forced drain.
  - When flush_pending & state==IDLE & sb_count==0: flush_done=1 at the next edge for 1 cycle, and flush_pending clears.
  - flush_req while already pending has no extra effect.
  - flush_req with empty SB in IDLE: flush_done 2 cycles later.
- Back-to-back drains: after WRITE, IDLE evaluates drain_go again. Minimum spacing is 2 cycles per entry.
- sb_count is sampled as supplied. The SB is responsible for the push/pop-same-cycle count.
- Reset low during REFILL: mem_req drops the same cycle, the FSM is in IDLE after the edge, and the pending refill is abandoned.

Test Plan:
1. sb_count=1, no mem op at cycle t, head_cache_hit=1 -> drain_state=WRITE at t+1 with sb_pop=cache_wr_en=1 for exactly one cycle, IDLE at t+2; pipe_stall stays 0.
2. sb_count=3, mem_is_load=1, head_cache_hit=1 -> pipe_stall=1 that cycle, WRITE next cycle, pipe_stall=1 again in WRITE while the load persists.
3. sb_count=2 with mem_is_load held high for 10 cycles -> wait_cnt reaches 7 on the 8th cycle, forced drain with pipe_stall=1, sb_pop one cycle later.
4. head_cache_hit=0, sb_count=1, port idle -> REFILL with mem_req=1 for 4 cycles, mem_ack on the 4th -> WRITE next cycle (sb_pop=1) -> IDLE.
5. flush_req with sb_count=2 under a continuous load stream -> two forced drains; once sb_count=0 in IDLE, flush_done pulses once. A second flush_req on an empty SB gives flush_done 2 cycles later.
6. reset driven low mid-REFILL -> mem_req=0 immediately; drain_state=0 and all outputs 0 after the edge. A later mem_ack is ignored and there is no spurious sb_pop.
